// File: rtl/maxigp_reg_scheduler.sv
// maxigp_reg_scheduler
//   Bridges the PS7 MAXIGP0 general-purpose master port onto a single-ported
//   register file. Read and write requests are arbitrated round-robin, and one
//   transaction is served at a time. Each burst is walked one beat at a time
//   onto the register port. R and B responses go back using ENA/RDY method
//   handshakes.
//
// Ports
//   CLK, nRST                 clock, asynchronous active-low reset
//   MAXIGP0_O_AR* / _AW*      read / write request channels (addr, id, len)
//   MAXIGP0_O_W*              write beat channel (data, id, last)
//   MAXIGP0_I_R*              read beat channel back to the master
//   MAXIGP0_I_B*              write response channel back to the master
//   reg_read__ENA/write__ENA  register strobes
//   reg_addr, reg_wdata       register word address and write data
//   reg_rdata                 register read data, valid the cycle after the read strobe
module maxigp_reg_scheduler #(
  parameter int ID_WIDTH   = 12,
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 10
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  MAXIGP0_O_AR__ENA,
  input  logic [31:0]           MAXIGP0_O_AR_addr,
  input  logic [ID_WIDTH-1:0]   MAXIGP0_O_AR_id,
  input  logic [3:0]            MAXIGP0_O_AR_len,
  output logic                  MAXIGP0_O_AR__RDY,
  input  logic                  MAXIGP0_O_AW__ENA,
  input  logic [31:0]           MAXIGP0_O_AW_addr,
  input  logic [ID_WIDTH-1:0]   MAXIGP0_O_AW_id,
  input  logic [3:0]            MAXIGP0_O_AW_len,
  output logic                  MAXIGP0_O_AW__RDY,
  input  logic                  MAXIGP0_O_W__ENA,
  input  logic [DATA_WIDTH-1:0] MAXIGP0_O_W_data,
  input  logic [ID_WIDTH-1:0]   MAXIGP0_O_W_id,
  input  logic                  MAXIGP0_O_W_last,
  output logic                  MAXIGP0_O_W__RDY,
  output logic                  MAXIGP0_I_R__ENA,
  output logic [DATA_WIDTH-1:0] MAXIGP0_I_R_data,
  output logic [ID_WIDTH-1:0]   MAXIGP0_I_R_id,
  output logic                  MAXIGP0_I_R_last,
  output logic [1:0]            MAXIGP0_I_R_resp,
  input  logic                  MAXIGP0_I_R__RDY,
  output logic                  MAXIGP0_I_B__ENA,
  output logic [ID_WIDTH-1:0]   MAXIGP0_I_B_id,
  output logic [1:0]            MAXIGP0_I_B_resp,
  input  logic                  MAXIGP0_I_B__RDY,
  output logic                  reg_read__ENA,
  output logic                  reg_write__ENA,
  output logic [REG_AW-1:0]     reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ISSUE = 3'd1;
  localparam logic [2:0] RD_DATA  = 3'd2;
  localparam logic [2:0] WR_DATA  = 3'd3;
  localparam logic [2:0] WR_RESP  = 3'd4;

  localparam logic RR_READ  = 1'b0;
  localparam logic RR_WRITE = 1'b1;

  logic [2:0]            state;
  logic                  rr_last;
  logic [ID_WIDTH-1:0]   id_q;
  logic [3:0]            len_q;
  logic [3:0]            beat_q;
  logic [REG_AW-1:0]     base_q;
  logic                  err_q;
  logic                  rd_first;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  ar_rdy;
  logic                  aw_rdy;
  logic                  last_beat;
  logic [REG_AW-1:0]     beat_addr;
  logic                  unused_addr_bits;

  assign last_beat = (beat_q == len_q);
  // Word address arithmetic is REG_AW wide, so bursts wrap naturally at the top of the file.
  assign beat_addr = base_q + REG_AW'(beat_q);

  // Only the word-address field of the byte address selects a register.
  assign unused_addr_bits = ^{MAXIGP0_O_AR_addr[31:REG_AW+2], MAXIGP0_O_AR_addr[1:0],
                              MAXIGP0_O_AW_addr[31:REG_AW+2], MAXIGP0_O_AW_addr[1:0]};

  // Round-robin grant in IDLE. A contested cycle goes to whichever side did not win
  // last time. The reset term keeps both accepts low while nRST is held.
  always_comb begin
    ar_rdy = 1'b0;
    aw_rdy = 1'b0;
    if (nRST && state == IDLE) begin
      ar_rdy = MAXIGP0_O_AR__ENA && (!MAXIGP0_O_AW__ENA || rr_last == RR_WRITE);
      aw_rdy = MAXIGP0_O_AW__ENA && (!MAXIGP0_O_AR__ENA || rr_last == RR_READ);
    end
  end

  assign MAXIGP0_O_AR__RDY = ar_rdy;
  assign MAXIGP0_O_AW__RDY = aw_rdy;
  assign MAXIGP0_O_W__RDY  = (state == WR_DATA);

  // The register port is driven straight from the FSM. Write beats pass through in the same cycle.
  assign reg_read__ENA  = (state == RD_ISSUE);
  assign reg_write__ENA = (state == WR_DATA) && MAXIGP0_O_W__ENA;
  assign reg_addr       = (state == RD_ISSUE || state == WR_DATA) ? beat_addr : '0;
  assign reg_wdata      = (state == WR_DATA) ? MAXIGP0_O_W_data : '0;

  // The register file presents read data only in the first RD_DATA cycle.
  // After that, the captured copy keeps R_data stable while the master stalls.
  assign MAXIGP0_I_R__ENA = (state == RD_DATA);
  assign MAXIGP0_I_R_data = (state != RD_DATA) ? '0 : (rd_first ? reg_rdata : rdata_q);
  assign MAXIGP0_I_R_id   = (state == RD_DATA) ? id_q : '0;
  assign MAXIGP0_I_R_last = (state == RD_DATA) && last_beat;
  assign MAXIGP0_I_R_resp = 2'b00;

  assign MAXIGP0_I_B__ENA = (state == WR_RESP);
  assign MAXIGP0_I_B_id   = (state == WR_RESP) ? id_q : '0;
  assign MAXIGP0_I_B_resp = (state == WR_RESP && err_q) ? 2'b10 : 2'b00;

  // Transaction sequencer. A burst runs until its beat count is used up.
  // W_last and W_id only feed the error flag, so a malformed burst still
  // writes every beat and still gets exactly one response.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      rr_last  <= RR_WRITE;
      id_q     <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      base_q   <= '0;
      err_q    <= 1'b0;
      rd_first <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_rdy) begin
            id_q    <= MAXIGP0_O_AR_id;
            len_q   <= MAXIGP0_O_AR_len;
            base_q  <= MAXIGP0_O_AR_addr[REG_AW+1:2];
            beat_q  <= '0;
            rr_last <= RR_READ;
            state   <= RD_ISSUE;
          end else if (aw_rdy) begin
            id_q    <= MAXIGP0_O_AW_id;
            len_q   <= MAXIGP0_O_AW_len;
            base_q  <= MAXIGP0_O_AW_addr[REG_AW+1:2];
            beat_q  <= '0;
            err_q   <= 1'b0;
            rr_last <= RR_WRITE;
            state   <= WR_DATA;
          end
        end
        RD_ISSUE: begin
          rd_first <= 1'b1;
          state    <= RD_DATA;
        end
        RD_DATA: begin
          rd_first <= 1'b0;
          if (rd_first) begin
            rdata_q <= reg_rdata;
          end
          if (MAXIGP0_I_R__RDY) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              beat_q <= beat_q + 4'd1;
              state  <= RD_ISSUE;
            end
          end
        end
        WR_DATA: begin
          if (MAXIGP0_O_W__ENA) begin
            err_q <= err_q | (MAXIGP0_O_W_id != id_q) | (MAXIGP0_O_W_last != last_beat);
            if (last_beat) begin
              state <= WR_RESP;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end
        WR_RESP: begin
          if (MAXIGP0_I_B__RDY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxigp_reg_scheduler.sv
// tb_maxigp_reg_scheduler
//   Directed bench for maxigp_reg_scheduler. A behavioural register file with a
//   one-cycle read latency sits on the register port. Every word starts as
//   32'h1000_0000 | index, except word 4, which holds 32'hA5A5A5A5.
//   Whole transactions come from a vector table. Hand-written sequences cover
//   the cycle-exact timing, stalls, arbitration and mid-burst reset.
module tb_maxigp_reg_scheduler;

  logic        clk;
  logic        rst_n;
  logic        ar_ena, ar_rdy, aw_ena, aw_rdy, w_ena, w_last, w_rdy;
  logic [31:0] ar_addr, aw_addr, w_data;
  logic [11:0] ar_id, aw_id, w_id;
  logic [3:0]  ar_len, aw_len;
  logic        r_ena, r_last, r_rdy, b_ena, b_rdy;
  logic [31:0] r_data;
  logic [11:0] r_id, b_id;
  logic [1:0]  r_resp, b_resp;
  logic        rd_en, wr_en;
  logic [9:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;

  int vec_count   = 0;
  int miscompares = 0;

  maxigp_reg_scheduler dut (
    .CLK(clk), .nRST(rst_n),
    .MAXIGP0_O_AR__ENA(ar_ena), .MAXIGP0_O_AR_addr(ar_addr), .MAXIGP0_O_AR_id(ar_id),
    .MAXIGP0_O_AR_len(ar_len), .MAXIGP0_O_AR__RDY(ar_rdy),
    .MAXIGP0_O_AW__ENA(aw_ena), .MAXIGP0_O_AW_addr(aw_addr), .MAXIGP0_O_AW_id(aw_id),
    .MAXIGP0_O_AW_len(aw_len), .MAXIGP0_O_AW__RDY(aw_rdy),
    .MAXIGP0_O_W__ENA(w_ena), .MAXIGP0_O_W_data(w_data), .MAXIGP0_O_W_id(w_id),
    .MAXIGP0_O_W_last(w_last), .MAXIGP0_O_W__RDY(w_rdy),
    .MAXIGP0_I_R__ENA(r_ena), .MAXIGP0_I_R_data(r_data), .MAXIGP0_I_R_id(r_id),
    .MAXIGP0_I_R_last(r_last), .MAXIGP0_I_R_resp(r_resp), .MAXIGP0_I_R__RDY(r_rdy),
    .MAXIGP0_I_B__ENA(b_ena), .MAXIGP0_I_B_id(b_id), .MAXIGP0_I_B_resp(b_resp),
    .MAXIGP0_I_B__RDY(b_rdy),
    .reg_read__ENA(rd_en), .reg_write__ENA(wr_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model. It fills itself on the first edge, then performs
  // synchronous writes and registered reads.
  logic [31:0] mem [0:1023];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 | 32'(i);
      mem[4]    <= 32'hA5A5_A5A5;
      mem_ready <= 1'b1;
    end else begin
      if (wr_en) mem[reg_addr] <= reg_wdata;
      if (rd_en) reg_rdata <= mem[reg_addr];
    end
  end

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [11:0] id;
    logic [3:0]  len;
    logic [31:0] data0;      // first beat data (expected for reads, driven for writes), +1 per beat
    logic [15:0] last_mask;  // beats driven with W_last high
    logic [15:0] badid_mask; // beats driven with a wrong W_id
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_ar;
    #1;
    for (int n = 0; n < 16 && !ar_rdy; n++) tick;
    check_output("ar_grant", ar_rdy, 1);
  endtask

  task automatic wait_aw;
    #1;
    for (int n = 0; n < 16 && !aw_rdy; n++) tick;
    check_output("aw_grant", aw_rdy, 1);
  endtask

  task automatic wait_r;
    for (int n = 0; n < 16 && !r_ena; n++) tick;
    check_output("r_ena_wait", r_ena, 1);
  endtask

  task automatic wait_b;
    for (int n = 0; n < 16 && !b_ena; n++) tick;
    check_output("b_ena_wait", b_ena, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ctrl"}, {ar_rdy, aw_rdy, w_rdy, r_ena, b_ena, rd_en, wr_en}, 0);
    check_output({tag, "_rpay"}, {r_data, r_id, r_last, r_resp}, 0);
    check_output({tag, "_bpay"}, {b_id, b_resp, reg_addr, reg_wdata}, 0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    ar_ena = 1'b1; aw_ena = 1'b1; w_ena = 1'b0; r_rdy = 1'b0; b_rdy = 1'b0;
    repeat (2) tick;
    check_all_zero("reset");
    ar_ena = 1'b0; aw_ena = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Runs one complete transaction from a vector and checks every beat and the response.
  task automatic apply_stimulus(input vec_t v);
    logic [9:0] ea;
    if (!v.is_wr) begin
      ar_ena = 1'b1; ar_addr = v.addr; ar_id = v.id; ar_len = v.len;
      wait_ar;
      tick;
      ar_ena = 1'b0;
      for (int b = 0; b <= int'(v.len); b++) begin
        wait_r;
        check_output("r_data", r_data, v.data0 + 32'(b));
        check_output("r_id", r_id, v.id);
        check_output("r_last", r_last, (b == int'(v.len)));
        check_output("r_resp", r_resp, 0);
        r_rdy = 1'b1;
        tick;
        r_rdy = 1'b0;
      end
    end else begin
      aw_ena = 1'b1; aw_addr = v.addr; aw_id = v.id; aw_len = v.len;
      wait_aw;
      tick;
      aw_ena = 1'b0;
      for (int b = 0; b <= int'(v.len); b++) begin
        ea = v.addr[11:2] + 10'(b);
        w_ena  = 1'b1;
        w_data = v.data0 + 32'(b);
        w_id   = v.badid_mask[b] ? ~v.id : v.id;
        w_last = v.last_mask[b];
        #1;
        check_output("w_strobe", {w_rdy, wr_en}, 2'b11);
        check_output("w_addr", reg_addr, ea);
        tick;
        w_ena = 1'b0; w_last = 1'b0;
      end
      wait_b;
      check_output("b_id", b_id, v.id);
      check_output("b_resp", b_resp, v.exp_resp);
      b_rdy = 1'b1;
      tick;
      b_rdy = 1'b0;
      for (int b = 0; b <= int'(v.len); b++) begin
        ea = v.addr[11:2] + 10'(b);
        check_output("mem_word", mem[ea], v.data0 + 32'(b));
      end
    end
  endtask

  // Single read at word 4. The read strobe is expected one cycle after the fire,
  // and the R beat two cycles after it.
  task automatic seq_read_timing;
    ar_ena = 1'b1; ar_addr = 32'h10; ar_id = 12'd5; ar_len = 4'd0;
    #1;
    check_output("A_ar_rdy", {ar_rdy, aw_rdy}, 2'b10);
    tick;
    ar_ena = 1'b0;
    #1;
    check_output("A_issue", {rd_en, r_ena}, 2'b10);
    check_output("A_issue_addr", reg_addr, 10'd4);
    tick;
    check_output("A_r_ena", {r_ena, rd_en}, 2'b10);
    check_output("A_r_data", r_data, 32'hA5A5_A5A5);
    check_output("A_r_meta", {r_id, r_last, r_resp}, {12'd5, 1'b1, 2'b00});
    r_rdy = 1'b1;
    tick;
    r_rdy = 1'b0;
    check_output("A_done", r_ena, 0);
  endtask

  // Two-beat read from the top word. The address must wrap to 0, and the first
  // beat is stalled for two cycles.
  task automatic seq_wrap_stall;
    ar_ena = 1'b1; ar_addr = 32'hFFC; ar_id = 12'h3A; ar_len = 4'd1;
    wait_ar;
    tick;
    ar_ena = 1'b0;
    #1;
    check_output("E_addr0", {rd_en, reg_addr}, {1'b1, 10'd1023});
    tick;
    for (int s = 0; s < 3; s++) begin
      check_output("E_beat0", {r_ena, r_last, r_data}, {1'b1, 1'b0, 32'h1000_03FF});
      if (s < 2) tick;
    end
    r_rdy = 1'b1;
    tick;
    r_rdy = 1'b0;
    check_output("E_addr1", {rd_en, reg_addr}, {1'b1, 10'd0});
    tick;
    check_output("E_beat1", {r_ena, r_last, r_data}, {1'b1, 1'b1, 32'h1000_0000});
    r_rdy = 1'b1;
    tick;
    r_rdy = 1'b0;
  endtask

  // Four-beat write at word 0. B is then held off for three cycles.
  task automatic seq_write_bstall;
    aw_ena = 1'b1; aw_addr = 32'h0; aw_id = 12'h21; aw_len = 4'd3;
    wait_aw;
    tick;
    aw_ena = 1'b0;
    for (int b = 0; b < 4; b++) begin
      w_ena = 1'b1; w_data = 32'(b + 1); w_id = 12'h21; w_last = (b == 3);
      #1;
      check_output("B_wr", {wr_en, reg_addr, reg_wdata}, {1'b1, 10'(b), 32'(b + 1)});
      tick;
    end
    w_ena = 1'b0; w_last = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check_output("B_hold", {b_ena, b_id, b_resp}, {1'b1, 12'h21, 2'b00});
      tick;
    end
    b_rdy = 1'b1;
    tick;
    b_rdy = 1'b0;
    check_output("B_done", b_ena, 0);
    for (int i = 0; i < 4; i++) check_output("B_mem", mem[i], 32'(i + 1));
  endtask

  // AR and AW are offered together three times in a row. Starting from reset,
  // the grants must go read, write, read.
  task automatic seq_arbitration;
    logic [1:0] exp_grant;
    for (int r = 0; r < 3; r++) begin
      exp_grant = (r == 1) ? 2'b01 : 2'b10;
      ar_ena = 1'b1; ar_addr = 32'h200; ar_id = 12'(r); ar_len = 4'd0;
      aw_ena = 1'b1; aw_addr = 32'h300; aw_id = 12'h100 + 12'(r); aw_len = 4'd0;
      #1;
      check_output("C_grant", {ar_rdy, aw_rdy}, exp_grant);
      tick;
      ar_ena = 1'b0; aw_ena = 1'b0;
      if (exp_grant == 2'b10) begin
        wait_r;
        check_output("C_r", {r_id, r_data}, {12'(r), 32'h1000_0080});
        r_rdy = 1'b1;
        tick;
        r_rdy = 1'b0;
      end else begin
        w_ena = 1'b1; w_data = 32'hC0C0_0000; w_id = 12'h100 + 12'(r); w_last = 1'b1;
        tick;
        w_ena = 1'b0; w_last = 1'b0;
        wait_b;
        check_output("C_b", {b_id, b_resp}, {12'h100 + 12'(r), 2'b00});
        b_rdy = 1'b1;
        tick;
        b_rdy = 1'b0;
      end
    end
  endtask

  // Reset arrives while the third beat of a four-beat read is on the R channel.
  // Everything must drop at once, and no leftover beat may appear afterwards.
  task automatic seq_reset_midburst;
    vec_t v;
    ar_ena = 1'b1; ar_addr = 32'h400; ar_id = 12'h77; ar_len = 4'd3;
    wait_ar;
    tick;
    ar_ena = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wait_r;
      check_output("F_r_data", r_data, 32'h1000_0100 + 32'(b));
      r_rdy = 1'b1;
      tick;
      r_rdy = 1'b0;
    end
    tick;
    check_output("F_beat2_up", r_ena, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("F_abort");
    tick;
    rst_n = 1'b1;
    tick;
    check_output("F_no_resp", {r_ena, b_ena}, 0);
    v = '{1'b0, 32'h10, 12'd6, 4'd0, 32'hA5A5_A5A5, 16'h0, 16'h0, 2'b00};
    apply_stimulus(v);
  endtask

  initial begin
    rst_n = 1'b0;
    ar_ena = 1'b0; ar_addr = '0; ar_id = '0; ar_len = '0;
    aw_ena = 1'b0; aw_addr = '0; aw_id = '0; aw_len = '0;
    w_ena = 1'b0; w_data = '0; w_id = '0; w_last = 1'b0;
    r_rdy = 1'b0; b_rdy = 1'b0;

    vecs[0]  = '{1'b0, 32'h020, 12'h123, 4'd2, 32'h1000_0008, 16'h0,   16'h0, 2'b00};
    vecs[1]  = '{1'b1, 32'h040, 12'h007, 4'd0, 32'hDEAD_0000, 16'h1,   16'h0, 2'b00};
    vecs[2]  = '{1'b0, 32'h040, 12'h008, 4'd0, 32'hDEAD_0000, 16'h0,   16'h0, 2'b00};
    vecs[3]  = '{1'b1, 32'h080, 12'h009, 4'd2, 32'h5555_0000, 16'h4,   16'h0, 2'b00};
    vecs[4]  = '{1'b0, 32'h084, 12'h001, 4'd1, 32'h5555_0001, 16'h0,   16'h0, 2'b00};
    vecs[5]  = '{1'b1, 32'h0C0, 12'h003, 4'd1, 32'h7777_0000, 16'h0,   16'h0, 2'b10};
    vecs[6]  = '{1'b0, 32'h0C0, 12'h002, 4'd1, 32'h7777_0000, 16'h0,   16'h0, 2'b00};
    vecs[7]  = '{1'b1, 32'h100, 12'h044, 4'd1, 32'h9999_0000, 16'h3,   16'h2, 2'b10};
    vecs[8]  = '{1'b0, 32'h100, 12'h045, 4'd1, 32'h9999_0000, 16'h0,   16'h0, 2'b00};
    vecs[9]  = '{1'b1, 32'h140, 12'hABC, 4'd0, 32'h1234_5678, 16'h1,   16'h1, 2'b10};
    vecs[10] = '{1'b0, 32'h3F0, 12'hFFF, 4'd3, 32'h1000_00FC, 16'h0,   16'h0, 2'b00};

    do_reset;
    seq_read_timing;
    seq_wrap_stall;
    seq_write_bstall;
    for (int i = 0; i < NVEC; i++) apply_stimulus(vecs[i]);
    do_reset;
    seq_arbitration;
    seq_reset_midburst;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
